// File: rtl/axi_master_engine.sv
// rtl/axi_master_engine.sv - AXI3 single-burst INCR master engine; optional 4 KB boundary reject under AXI_MASTER_4K_CHECK_EN
module axi_master_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    aclk,
    input  logic                    arst,
    // command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [3:0]              cmd_len,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    // user write data stream
    input  logic [DATA_WIDTH-1:0]   usr_wdata,
    input  logic                    usr_wvalid,
    output logic                    usr_wready,
    // user read data stream
    output logic [DATA_WIDTH-1:0]   usr_rdata,
    output logic                    usr_rvalid,
    output logic                    usr_rlast,
    input  logic                    usr_rready,
    // completion
    output logic                    done,
    output logic [1:0]              done_resp,
    // AW channel
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic [3:0]              awqos,
    output logic [3:0]              awregion,
    output logic                    awvalid,
    input  logic                    awready,
    // W channel
    output logic [ID_WIDTH-1:0]     wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    // B channel
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    // AR channel
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic [3:0]              arqos,
    output logic [3:0]              arregion,
    output logic                    arvalid,
    input  logic                    arready,
    // R channel
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int         BYTES  = DATA_WIDTH / 8;
    localparam logic [2:0] AXSIZE = 3'($clog2(BYTES));

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              len_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [4:0]              beat_q;     // one spare bit so an over-long read burst is still seen as a mismatch
    logic [1:0]              resp_q;
    logic                    err_q;
    logic                    cmd_ready_q;

    logic                    cmd_fire;
    logic                    cmd_reject;
    logic                    w_fire;
    logic                    r_fire;
    logic [1:0]              rd_max;
    logic                    rd_bad;

    assign cmd_fire = (state == IDLE) && cmd_valid && cmd_ready_q;
    assign w_fire   = wvalid && wready;
    assign r_fire   = rvalid && rready;

`ifdef AXI_MASTER_4K_CHECK_EN
    logic [15:0] burst_end;

    // Reject a command whose last byte lands past the 4 KB page it starts in
    always_comb begin
        burst_end  = 16'(cmd_addr[11:0]) + ((16'(cmd_len) + 16'd1) * 16'(BYTES));
        cmd_reject = (burst_end > 16'd4096);
    end
`else
    assign cmd_reject = 1'b0;
`endif

    // Read-side status: worst response so far, and any protocol error (ID or beat count)
    always_comb begin
        rd_max = (rresp > resp_q) ? rresp : resp_q;
        rd_bad = err_q || (rid != id_q) || (rlast && (beat_q != {1'b0, len_q}));
    end

    // Fixed burst attributes and latched command payload
    assign awid     = id_q;
    assign awaddr   = addr_q;
    assign awlen    = len_q;
    assign awsize   = AXSIZE;
    assign awburst  = 2'b01;
    assign awlock   = 2'b00;
    assign awcache  = 4'd0;
    assign awprot   = 3'd0;
    assign awqos    = 4'd0;
    assign awregion = 4'd0;
    assign arid     = id_q;
    assign araddr   = addr_q;
    assign arlen    = len_q;
    assign arsize   = AXSIZE;
    assign arburst  = 2'b01;
    assign arlock   = 2'b00;
    assign arcache  = 4'd0;
    assign arprot   = 3'd0;
    assign arqos    = 4'd0;
    assign arregion = 4'd0;

    assign wid       = id_q;
    assign wdata     = usr_wdata;
    assign wstrb     = '1;
    assign wlast     = (state == WR_DATA) && (beat_q == {1'b0, len_q});
    assign usr_rdata = rdata;
    assign usr_rlast = rlast && (state == RD_DATA);
    assign cmd_ready = cmd_ready_q;
    assign done_resp = resp_q;

    // State register
    always_ff @(posedge aclk) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and channel handshake outputs
    always_comb begin
        state_next = state;
        awvalid    = 1'b0;
        arvalid    = 1'b0;
        wvalid     = 1'b0;
        usr_wready = 1'b0;
        bready     = 1'b0;
        rready     = 1'b0;
        usr_rvalid = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_reject) begin
                        state_next = DONE;
                    end else if (cmd_write) begin
                        state_next = WR_ADDR;
                    end else begin
                        state_next = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                wvalid     = usr_wvalid;
                usr_wready = wready;
                if (usr_wvalid && wready && wlast) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = DONE;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                rready     = usr_rready;
                usr_rvalid = rvalid;
                if (rvalid && usr_rready && rlast) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // cmd_ready is registered so it only rises the cycle after reset or DONE
    always_ff @(posedge aclk) begin
        if (arst) begin
            cmd_ready_q <= 1'b0;
        end else begin
            cmd_ready_q <= (state_next == IDLE);
        end
    end

    // Command latch, beat counter and response accumulation
    always_ff @(posedge aclk) begin
        if (arst) begin
            addr_q <= '0;
            len_q  <= '0;
            id_q   <= '0;
            beat_q <= '0;
            resp_q <= 2'b00;
            err_q  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                id_q   <= cmd_id;
                beat_q <= '0;
                err_q  <= 1'b0;
                resp_q <= cmd_reject ? 2'b10 : 2'b00;
            end
            if ((state == WR_DATA) && w_fire) begin
                beat_q <= beat_q + 5'd1;
            end
            if ((state == WR_RESP) && bvalid) begin
                resp_q <= (bid != id_q) ? 2'b10 : bresp;
            end
            if ((state == RD_DATA) && r_fire) begin
                beat_q <= beat_q + 5'd1;
                err_q  <= rd_bad;
                if (rlast) begin
                    resp_q <= rd_bad ? 2'b10 : rd_max;
                end else begin
                    resp_q <= rd_max;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_master_engine.sv
// tb/tb_axi_master_engine.sv - scoreboard bench for axi_master_engine against a behavioural AXI slave
module tb_axi_master_engine;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic aclk = 1'b0;
    logic arst;
    always #5 aclk = ~aclk;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    cmd_len;
    logic [IW-1:0] cmd_id;
    logic [DW-1:0] usr_wdata, usr_rdata;
    logic          usr_wvalid, usr_wready, usr_rvalid, usr_rlast, usr_rready;
    logic          done;
    logic [1:0]    done_resp;
    logic [IW-1:0] awid, wid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [3:0]    awlen, arlen, awcache, arcache, awqos, arqos, awregion, arregion;
    logic [2:0]    awsize, arsize, awprot, arprot;
    logic [1:0]    awburst, arburst, awlock, arlock, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;

    axi_master_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .aclk(aclk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .usr_wdata(usr_wdata), .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
        .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid), .usr_rlast(usr_rlast), .usr_rready(usr_rready),
        .done(done), .done_resp(done_resp),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [31:0] addr; logic [3:0] len; logic [3:0] id; } addr_t;
    typedef struct { logic [31:0] data; logic last; } rbeat_t;

    addr_t       exp_aw[$];
    addr_t       exp_ar[$];
    logic [31:0] exp_w[$];
    logic [31:0] feed[$];
    rbeat_t      exp_r[$];
    logic [1:0]  exp_done[$];
    logic [31:0] ref_mem[int];
    rbeat_t      mon_e;

    int         aw_stall   = 0;
    logic [1:0] bresp_knob = 2'b00;
    logic [3:0] bid_xor    = 4'd0;
    int         rerr_beat  = -1;
    bit         gap_en     = 1'b0;
    bit         rtoggle    = 1'b0;

    logic [31:0] mem [0:1023];
    bit          aw_got, b_pend, ar_got, aw_hold;
    logic [31:0] aw_addr_s, ar_addr_s;
    logic [3:0]  aw_len_s, ar_len_s, aw_id_s, ar_id_s;
    int          w_beat, r_beat, aw_seen;
    logic [9:0]  widx, ridx;

    // Behavioural slave: drive at negedge, evaluate the upcoming handshakes 1 ns later
    initial begin
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
        aw_got = 0; b_pend = 0; ar_got = 0; aw_hold = 0;
        aw_addr_s = 0; ar_addr_s = 0; aw_len_s = 0; ar_len_s = 0; aw_id_s = 0; ar_id_s = 0;
        w_beat = 0; r_beat = 0; aw_seen = 0;
        forever begin
            @(negedge aclk);
            awready = !aw_got && !b_pend && (aw_seen >= aw_stall);
            wready  = aw_got;
            bvalid  = b_pend;
            bid     = aw_id_s ^ bid_xor;
            bresp   = bresp_knob;
            arready = !ar_got;
            rvalid  = ar_got;
            ridx    = ar_addr_s[11:2] + 10'(r_beat);
            rdata   = mem[ridx];
            rlast   = ar_got && (r_beat == int'(ar_len_s));
            rresp   = (ar_got && (r_beat == rerr_beat)) ? 2'b10 : 2'b00;
            rid     = ar_id_s;
            #1;
            if (arst) begin
                aw_got = 0; b_pend = 0; ar_got = 0; aw_hold = 0;
                w_beat = 0; r_beat = 0; aw_seen = 0;
            end else begin
                if (wvalid) begin
                    check("w_after_aw", aw_got, 1);
                    if (wready) begin
                        widx = aw_addr_s[11:2] + 10'(w_beat);
                        mem[widx] = wdata;
                        check("wid", wid, aw_id_s);
                        check("wstrb", wstrb, 4'hF);
                        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                        else check("wdata", wdata, exp_w.pop_front());
                        check("wlast", wlast, w_beat == int'(aw_len_s));
                        if (wlast) begin
                            aw_got = 0;
                            b_pend = 1;
                        end
                        w_beat++;
                    end
                end
                if (bvalid && bready) b_pend = 0;
                if (aw_hold) check("awvalid_held", awvalid, 1);
                aw_hold = 0;
                if (awvalid) begin
                    if (exp_aw.size() == 0) begin
                        check("aw_unexpected", 1, 0);
                    end else begin
                        check("awaddr", awaddr, exp_aw[0].addr);
                        check("awlen", awlen, exp_aw[0].len);
                        check("awid", awid, exp_aw[0].id);
                    end
                    if (awready) begin
                        check("awsize", awsize, 3'd2);
                        check("awburst", awburst, 2'b01);
                        aw_got = 1; aw_addr_s = awaddr; aw_len_s = awlen; aw_id_s = awid;
                        w_beat = 0; aw_seen = 0;
                        if (exp_aw.size() > 0) void'(exp_aw.pop_front());
                    end else begin
                        aw_seen++;
                        aw_hold = 1;
                    end
                end
                if (ar_got) check("rready_tracks", rready, usr_rready);
                if (rvalid && rready) begin
                    r_beat++;
                    if (rlast) ar_got = 0;
                end
                if (arvalid) begin
                    if (exp_ar.size() == 0) begin
                        check("ar_unexpected", 1, 0);
                    end else begin
                        check("araddr", araddr, exp_ar[0].addr);
                        check("arlen", arlen, exp_ar[0].len);
                        check("arid", arid, exp_ar[0].id);
                    end
                    if (arready) begin
                        check("arsize", arsize, 3'd2);
                        ar_got = 1; ar_addr_s = araddr; ar_len_s = arlen; ar_id_s = arid;
                        r_beat = 0;
                        if (exp_ar.size() > 0) void'(exp_ar.pop_front());
                    end
                end
            end
        end
    end

    // User-side source/sink and completion monitor
    initial begin
        usr_wvalid = 0; usr_wdata = 0; usr_rready = 0;
        forever begin
            @(negedge aclk);
            if (feed.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
                usr_wvalid = 1;
                usr_wdata  = feed[0];
            end else begin
                usr_wvalid = 0;
            end
            usr_rready = rtoggle ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (arst) begin
                feed.delete();
            end else begin
                if (usr_wvalid && usr_wready) void'(feed.pop_front());
                if (usr_rvalid && usr_rready) begin
                    if (exp_r.size() == 0) begin
                        check("r_unexpected", 1, 0);
                    end else begin
                        mon_e = exp_r.pop_front();
                        check("usr_rdata", usr_rdata, mon_e.data);
                        check("usr_rlast", usr_rlast, mon_e.last);
                    end
                end
                if (done) begin
                    check("cmd_ready_in_done", cmd_ready, 0);
                    if (exp_done.size() == 0) check("done_unexpected", 1, 0);
                    else check("done_resp", done_resp, exp_done.pop_front());
                end
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] id, input logic [1:0] resp, input bit expect_bus);
        addr_t a;
        int n;
        a.addr = addr; a.len = len; a.id = id;
        if (expect_bus) begin
            if (wr) exp_aw.push_back(a);
            else exp_ar.push_back(a);
        end
        exp_done.push_back(resp);
        @(negedge aclk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        #1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            #1;
            n++;
        end
        check("cmd_accept", cmd_ready, 1);
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        check("done_timeout", exp_done.size(), 0);
        check("w_left", exp_w.size(), 0);
        check("r_left", exp_r.size(), 0);
        check("aw_left", exp_aw.size(), 0);
        check("ar_left", exp_ar.size(), 0);
        exp_done.delete(); exp_w.delete(); exp_r.delete(); exp_aw.delete(); exp_ar.delete();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input logic [1:0] resp, input bit fixed);
        logic [31:0] d;
        for (int i = 0; i <= int'(len); i++) begin
            d = fixed ? 32'(32'hA0 + i) : $urandom;
            exp_w.push_back(d);
            feed.push_back(d);
            ref_mem[int'(addr >> 2) + i] = d;
        end
        issue(1'b1, addr, len, id, resp, 1'b1);
        wait_done();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                           input logic [1:0] resp);
        rbeat_t e;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = ref_mem[int'(addr >> 2) + i];
            e.last = (i == int'(len));
            exp_r.push_back(e);
        end
        issue(1'b0, addr, len, id, resp, 1'b1);
        wait_done();
    endtask

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        arst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        @(negedge aclk);
        // a command offered during reset must be ignored
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_len = 4'd1; cmd_id = 4'd9;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_done", done, 0);
        check("rst_done_resp", done_resp, 0);
        check("rst_usr_rvalid", usr_rvalid, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", awlen, 0);
        check("rst_awid", awid, 0);
        cmd_valid = 0;
        arst = 0;
        @(negedge aclk);
        #1;
        check("cmd_ready_after_rst", cmd_ready, 1);
        check("rst_cmd_not_taken", awvalid, 0);

        do_write(32'h100, 4'd3, 4'd5, 2'b00, 1'b1);
        do_read(32'h100, 4'd3, 4'd5, 2'b00);

        aw_stall = 5; gap_en = 1;
        do_write(32'h200, 4'd7, 4'd3, 2'b00, 1'b0);
        aw_stall = 0; gap_en = 0; rtoggle = 1;
        do_read(32'h200, 4'd7, 4'd3, 2'b00);
        rtoggle = 0;

        bresp_knob = 2'b11;
        do_write(32'h300, 4'd0, 4'd1, 2'b11, 1'b0);
        bresp_knob = 2'b00;
        do_read(32'h300, 4'd0, 4'd1, 2'b00);

        bid_xor = 4'd1;
        do_write(32'h340, 4'd1, 4'd2, 2'b10, 1'b0);
        bid_xor = 4'd0;

        rerr_beat = 1;
        do_read(32'h100, 4'd3, 4'd5, 2'b10);
        rerr_beat = -1;

        do_write(32'h380, 4'd15, 4'd15, 2'b00, 1'b0);
        do_read(32'h380, 4'd15, 4'd15, 2'b00);

        // reset in the middle of a write burst, after the first data beat
        for (int i = 0; i < 4; i++) begin
            exp_w.push_back(32'(32'hB0 + i));
            feed.push_back(32'(32'hB0 + i));
        end
        issue(1'b1, 32'h400, 4'd3, 4'd7, 2'b00, 1'b1);
        n = 0;
        while (w_beat < 1 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        check("midrst_first_beat", w_beat >= 1, 1);
        arst = 1;
        @(negedge aclk);
        #1;
        check("midrst_awvalid", awvalid, 0);
        check("midrst_wvalid", wvalid, 0);
        check("midrst_usr_wready", usr_wready, 0);
        check("midrst_arvalid", arvalid, 0);
        check("midrst_bready", bready, 0);
        check("midrst_rready", rready, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        check("midrst_done", done, 0);
        exp_done.delete(); exp_w.delete(); exp_aw.delete(); exp_ar.delete(); exp_r.delete();
        arst = 0;
        @(negedge aclk);
        #1;
        check("midrst_cmd_ready_after", cmd_ready, 1);
        do_write(32'h500, 4'd3, 4'd4, 2'b00, 1'b0);
        do_read(32'h500, 4'd3, 4'd4, 2'b00);

`ifdef AXI_MASTER_4K_CHECK_EN
        issue(1'b1, 32'hFF8, 4'd3, 4'd2, 2'b10, 1'b0);
        wait_done();
`else
        do_write(32'hFF8, 4'd3, 4'd2, 2'b00, 1'b0);
`endif

        repeat (3) @(negedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
